fetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of the core's decoder. It holds the fetch PC, issues word reads to a synchronous instruction memory, and buffers returned words with their PCs in a small queue. It presents one instruction per cycle to the decoder over a valid/ready handshake. A redirect from execute (branch or jump) flushes all buffered and in-flight fetches and restarts fetching at the new target.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_if.sv | 25 ++
 rtl/inst_queue.sv | 47 ++++
 rtl/fetch_unit.sv | 62 ++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath widths, queue entry layout and
// the default reset PC.
package fetch_unit_pkg;
  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect from execute, instruction memory port and
// decoder handshake. The slave modport is the fetch unit itself.
interface fetch_if;
  import fetch_unit_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output redirect, redirect_pc, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    input  redirect, redirect_pc, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of fetched {inst, pc} entries with synchronous flush.
// Storage resets to zero so the head reads as zero straight out of reset.
module inst_queue
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited reads to a
// one-cycle synchronous memory and queues returned words for the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  fetch_entry_t    head;
  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic            inflight, pop, push, issue;
  logic [CW:0]     used, limit;

  assign bus.inst_valid = (count != '0) && !bus.redirect;
  assign pop            = bus.inst_valid && bus.inst_ready;

  // Credit: queued + in-flight words, less the one leaving now, must fit.
  assign used  = (CW+1)'(count) + (CW+1)'(inflight);
  assign limit = (CW+1)'(DEPTH) + (CW+1)'(pop);
  assign issue = !rst && !bus.redirect && (used < limit);
  assign push  = inflight && !bus.redirect;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.inst      = head.inst;
  assign bus.inst_pc   = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ~XLEN'(INST_BYTES - 1);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(INST_BYTES);
        inflight_pc <= fetch_pc;
      end
    end
  end

  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fetch_entry_t'{inst: bus.imem_rdata, pc: inflight_pc}),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (count),
    .head      (head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus loads the expected PC stream,
// a negedge monitor checks every accepted instruction against it.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int pops   = 0;
  logic [31:0] exp_q [$];

  // Synchronous memory: word returned one cycle after the request.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? (bus.imem_addr ^ K) : $urandom();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req),   32'd0);
    chk({tag, "_addr"},  bus.imem_addr,       32'h0);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"},  bus.inst,            32'h0);
    chk({tag, "_pc"},    bus.inst_pc,         32'h0);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL deliver_empty: got pc %h expected no delivery", bus.inst_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.inst_pc === e && bus.inst === (e ^ K)) passes++;
        else $display("FAIL deliver: got pc %h inst %h expected pc %h inst %h",
                      bus.inst_pc, bus.inst, e, e ^ K);
      end
    end
  end

  initial begin
    int p0;
    int since;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;

    repeat (3) step;
    at_neg;
    chk_reset_vals("reset");

    // Start-up with decoder stalled: two issues, then credit runs out.
    step;
    rst = 1'b0;
    load(32'h0);
    at_neg;
    chk("c0_req",  32'(bus.imem_req), 32'd1);
    chk("c0_addr", bus.imem_addr,     32'h0);
    step; at_neg;
    chk("c1_req",   32'(bus.imem_req),   32'd1);
    chk("c1_addr",  bus.imem_addr,       32'h4);
    chk("c1_valid", 32'(bus.inst_valid), 32'd0);
    step; at_neg;
    chk("c2_valid", 32'(bus.inst_valid), 32'd1);
    chk("c2_pc",    bus.inst_pc,         32'h0);
    chk("c2_req",   32'(bus.imem_req),   32'd0);
    repeat (4) begin
      step; at_neg;
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end

    // Ready returns: issue restarts in the same cycle.
    step;
    bus.inst_ready = 1'b1;
    at_neg;
    chk("restart_req",  32'(bus.imem_req), 32'd1);
    chk("restart_addr", bus.imem_addr,     32'h8);
    repeat (10) begin
      step; at_neg;
      chk("tput_valid", 32'(bus.inst_valid), 32'd1);
    end

    // Fill the queue, pulse ready once, then redirect with a word in flight.
    step; bus.inst_ready = 1'b0;
    repeat (3) step;
    bus.inst_ready = 1'b1;
    step;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    load(32'h100);
    at_neg;
    chk("rd_valid", 32'(bus.inst_valid), 32'd0);
    chk("rd_req",   32'(bus.imem_req),   32'd0);
    step;
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    at_neg;
    chk("rd1_req",  32'(bus.imem_req), 32'd1);
    chk("rd1_addr", bus.imem_addr,     32'h100);
    step; at_neg;
    chk("rd2_valid", 32'(bus.inst_valid), 32'd0);
    step; at_neg;
    chk("rd3_valid", 32'(bus.inst_valid), 32'd1);
    chk("rd3_pc",    bus.inst_pc,         32'h100);
    repeat (5) step;

    // Wrap-around through the top of the address space.
    p0 = pops;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    load(32'hFFFF_FFF8);
    step;
    bus.redirect = 1'b0;
    repeat (8) step;
    chk("wrap_delivered", 32'(pops - p0 >= 3), 32'd1);

    // Asynchronous reset between edges with traffic in flight.
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    at_neg;
    step;
    rst = 1'b0;
    load(32'h0);
    at_neg;
    chk("post_rst_req",  32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr,     32'h0);

    // Random ready with sparse (occasionally back-to-back) redirects.
    p0    = pops;
    since = 0;
    repeat (10000) begin
      step;
      bus.redirect   = 1'b0;
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      if (since >= 100 || $urandom_range(0, 31) == 0) begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = $urandom();
        load(bus.redirect_pc & 32'hFFFF_FFFC);
        since = 0;
      end else begin
        since++;
      end
    end
    step;
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b0;
    chk("rand_delivered", 32'(pops - p0 > 2000), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
